// File: rtl/bsg_dfi_cmd_fifo_bridge_if.sv
// DFI command/data bus plus host-side command, write-beat and read-beat streams for the DFI FIFO bridge.
// The slave modport is the bridge; the master modport is the controller/host side driving it.
interface bsg_dfi_cmd_fifo_bridge_if #(
  parameter int bank_width_p     = 3,
  parameter int row_width_p      = 16,
  parameter int col_width_p      = 10,
  parameter int dfi_data_width_p = 32
);
  localparam int num_banks_lp = 1 << bank_width_p;
  localparam int cmd_width_lp = 1 + bank_width_p + row_width_p + col_width_p;
  localparam int mask_width_lp = dfi_data_width_p >> 3;

  logic [bank_width_p-1:0]     dfi_bank_i;
  logic [15:0]                 dfi_address_i;
  logic                        dfi_cs_n_i;
  logic                        dfi_ras_n_i;
  logic                        dfi_cas_n_i;
  logic                        dfi_we_n_i;
  logic                        dfi_wrdata_en_i;
  logic [dfi_data_width_p-1:0] dfi_wrdata_i;
  logic [mask_width_lp-1:0]    dfi_wrdata_mask_i;
  logic                        dfi_rddata_en_i;
  logic [dfi_data_width_p-1:0] dfi_rddata_o;
  logic                        dfi_rddata_valid_o;

  logic                        cmd_v_o;
  logic [cmd_width_lp-1:0]     cmd_data_o;
  logic                        cmd_ready_i;

  logic                        wr_v_o;
  logic [dfi_data_width_p-1:0] wr_data_o;
  logic [mask_width_lp-1:0]    wr_mask_o;
  logic                        wr_ready_i;

  logic                        rd_v_i;
  logic [dfi_data_width_p-1:0] rd_data_i;
  logic                        rd_yumi_o;

  logic [num_banks_lp-1:0]     open_banks_o;
  logic                        error_o;

  modport slave (
    input  dfi_bank_i, dfi_address_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i,
    input  dfi_wrdata_en_i, dfi_wrdata_i, dfi_wrdata_mask_i, dfi_rddata_en_i,
    output dfi_rddata_o, dfi_rddata_valid_o,
    output cmd_v_o, cmd_data_o, input cmd_ready_i,
    output wr_v_o, wr_data_o, wr_mask_o, input wr_ready_i,
    input  rd_v_i, rd_data_i, output rd_yumi_o,
    output open_banks_o, error_o
  );

  modport master (
    output dfi_bank_i, dfi_address_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i,
    output dfi_wrdata_en_i, dfi_wrdata_i, dfi_wrdata_mask_i, dfi_rddata_en_i,
    input  dfi_rddata_o, dfi_rddata_valid_o,
    input  cmd_v_o, cmd_data_o, output cmd_ready_i,
    input  wr_v_o, wr_data_o, wr_mask_o, output wr_ready_i,
    output rd_v_i, rd_data_i, input rd_yumi_o,
    input  open_banks_o, error_o
  );
endinterface

// File: rtl/bsg_dfi_cmd_fifo_bridge.sv
// DFI-to-FIFO bridge: tracks open rows per bank, queues full-address RD/WR packets (1-cycle latency), drops on full FIFO or stalled write beat and flags sticky error_o.
// Define BSG_DFI_CMD_BRIDGE_ROW_CHECK_EN to add closed-bank RD/WR and double-ACT protocol checks.
module bsg_dfi_cmd_fifo_bridge #(
  parameter int bank_width_p     = 3,
  parameter int row_width_p      = 16,
  parameter int col_width_p      = 10,
  parameter int dfi_data_width_p = 32,
  parameter int cmd_els_p        = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_dfi_cmd_fifo_bridge_if.slave bus
);
  localparam int num_banks_lp  = 1 << bank_width_p;
  localparam int cmd_width_lp  = 1 + bank_width_p + row_width_p + col_width_p;
  localparam int mask_width_lp = dfi_data_width_p >> 3;
  localparam int ptr_width_lp  = $clog2(cmd_els_p);
  localparam logic [dfi_data_width_p-1:0] dead_data_lp = {(dfi_data_width_p/32){32'hDEADBEEF}};

  logic                    cmd_sel;
  logic [2:0]              rcw;
  logic                    is_act, is_rd, is_wr, is_pre, is_rw, a10;
  logic [bank_width_p-1:0] bank;
  logic [row_width_p-1:0]  pkt_row;
  logic [cmd_width_lp-1:0] enq_pkt;
  logic                    proto_err;

  logic [row_width_p-1:0]  open_row_r [num_banks_lp];
  logic [num_banks_lp-1:0] open_banks_r;

  assign cmd_sel = ~bus.dfi_cs_n_i;
  assign rcw     = {bus.dfi_ras_n_i, bus.dfi_cas_n_i, bus.dfi_we_n_i};
  assign is_act  = cmd_sel & (rcw == 3'b011);
  assign is_rd   = cmd_sel & (rcw == 3'b101);
  assign is_wr   = cmd_sel & (rcw == 3'b100);
  assign is_pre  = cmd_sel & (rcw == 3'b010);
  assign is_rw   = is_rd | is_wr;
  assign a10     = bus.dfi_address_i[10];
  assign bank    = bus.dfi_bank_i;

`ifdef BSG_DFI_CMD_BRIDGE_ROW_CHECK_EN
  assign pkt_row   = open_banks_r[bank] ? open_row_r[bank] : '0;
  assign proto_err = (is_act & open_banks_r[bank]) | (is_rw & ~open_banks_r[bank]);
`else
  assign pkt_row   = open_row_r[bank];
  assign proto_err = 1'b0;
`endif

  assign enq_pkt = {is_wr, bank, pkt_row, bus.dfi_address_i[col_width_p-1:0]};

  // Extra MSB on each pointer separates full from empty when the low bits match.
  logic [ptr_width_lp:0]   wptr_r, rptr_r;
  logic [cmd_width_lp-1:0] mem_r [cmd_els_p];
  logic                    fifo_empty, fifo_full, deq, enq_ok, overflow;

  assign fifo_empty = (wptr_r == rptr_r);
  assign fifo_full  = (wptr_r[ptr_width_lp] != rptr_r[ptr_width_lp])
                    && (wptr_r[ptr_width_lp-1:0] == rptr_r[ptr_width_lp-1:0]);
  assign deq        = ~fifo_empty & bus.cmd_ready_i;
  assign enq_ok     = is_rw & (~fifo_full | deq);
  assign overflow   = is_rw & fifo_full & ~deq;

  always_ff @(posedge clk_i) begin
    if (enq_ok) mem_r[wptr_r[ptr_width_lp-1:0]] <= enq_pkt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq_ok) wptr_r <= wptr_r + 1'b1;
      if (deq)    rptr_r <= rptr_r + 1'b1;
    end
  end

  assign bus.cmd_v_o    = ~fifo_empty;
  assign bus.cmd_data_o = mem_r[rptr_r[ptr_width_lp-1:0]];

  // Auto-precharge closes the bank in the same cycle its RD/WR is queued.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      open_banks_r <= '0;
      for (int b = 0; b < num_banks_lp; b++) open_row_r[b] <= '0;
    end else begin
      for (int b = 0; b < num_banks_lp; b++) begin
        if (is_act && bank == bank_width_p'(b)) begin
          open_banks_r[b] <= 1'b1;
          open_row_r[b]   <= bus.dfi_address_i[row_width_p-1:0];
        end else if ((is_pre && (a10 || bank == bank_width_p'(b)))
                     || (is_rw && a10 && bank == bank_width_p'(b))) begin
          open_banks_r[b] <= 1'b0;
        end
      end
    end
  end

  assign bus.open_banks_o = open_banks_r;

  logic                        wr_v_r;
  logic [dfi_data_width_p-1:0] wr_data_r;
  logic [mask_width_lp-1:0]    wr_mask_r;
  logic                        rd_valid_r;
  logic [dfi_data_width_p-1:0] rd_data_r;
  logic                        error_r;
  logic                        wr_lost, rd_miss;

  assign wr_lost = wr_v_r & ~bus.wr_ready_i;
  assign rd_miss = bus.dfi_rddata_en_i & ~bus.rd_v_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_v_r     <= 1'b0;
      wr_data_r  <= '0;
      wr_mask_r  <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      error_r    <= 1'b0;
    end else begin
      wr_v_r     <= bus.dfi_wrdata_en_i;
      wr_data_r  <= bus.dfi_wrdata_i;
      wr_mask_r  <= bus.dfi_wrdata_mask_i;
      rd_valid_r <= bus.dfi_rddata_en_i;
      if (bus.dfi_rddata_en_i) rd_data_r <= bus.rd_v_i ? bus.rd_data_i : dead_data_lp;
      if (overflow | wr_lost | rd_miss | proto_err) error_r <= 1'b1;
    end
  end

  assign bus.wr_v_o             = wr_v_r;
  assign bus.wr_data_o          = wr_data_r;
  assign bus.wr_mask_o          = wr_mask_r;
  assign bus.dfi_rddata_valid_o = rd_valid_r;
  assign bus.dfi_rddata_o       = rd_data_r;
  assign bus.rd_yumi_o          = bus.dfi_rddata_en_i & bus.rd_v_i;
  assign bus.error_o            = error_r;
endmodule

// File: tb/tb_bsg_dfi_cmd_fifo_bridge.sv
// Bench for bsg_dfi_cmd_fifo_bridge: directed vector table, corner sequences, then random traffic against a queue model.
module tb_bsg_dfi_cmd_fifo_bridge;
  localparam int BW = 3, RW = 16, CW = 10, DW = 32, ELS = 4;
  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_PRE = 3'b010, C_NOP = 3'b111;
`ifdef BSG_DFI_CMD_BRIDGE_ROW_CHECK_EN
  localparam bit ROWCHK = 1'b1;
`else
  localparam bit ROWCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsg_dfi_cmd_fifo_bridge_if #(.bank_width_p(BW), .row_width_p(RW), .col_width_p(CW),
                               .dfi_data_width_p(DW)) bus ();

  bsg_dfi_cmd_fifo_bridge #(.bank_width_p(BW), .row_width_p(RW), .col_width_p(CW),
                            .dfi_data_width_p(DW), .cmd_els_p(ELS))
    dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] pkt(input bit w, input logic [2:0] b, input logic [15:0] r,
                                      input logic [9:0] c);
    return {w, b, r, c};
  endfunction

  task automatic idle();
    bus.dfi_cs_n_i = 1'b1;
    {bus.dfi_ras_n_i, bus.dfi_cas_n_i, bus.dfi_we_n_i} = C_NOP;
    bus.dfi_bank_i = '0;
    bus.dfi_address_i = '0;
    bus.dfi_wrdata_en_i = 1'b0;
    bus.dfi_wrdata_i = '0;
    bus.dfi_wrdata_mask_i = '0;
    bus.dfi_rddata_en_i = 1'b0;
    bus.cmd_ready_i = 1'b0;
    bus.wr_ready_i = 1'b1;
    bus.rd_v_i = 1'b0;
    bus.rd_data_i = '0;
  endtask

  task automatic set_cmd(input logic cs_n, input logic [2:0] c, input logic [2:0] b,
                         input logic [15:0] a);
    bus.dfi_cs_n_i = cs_n;
    {bus.dfi_ras_n_i, bus.dfi_cas_n_i, bus.dfi_we_n_i} = c;
    bus.dfi_bank_i = b;
    bus.dfi_address_i = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_v"}, 64'(bus.cmd_v_o), 64'd0);
    chk({tag, "_wr_v"}, 64'(bus.wr_v_o), 64'd0);
    chk({tag, "_rd_valid"}, 64'(bus.dfi_rddata_valid_o), 64'd0);
    chk({tag, "_rd_data"}, 64'(bus.dfi_rddata_o), 64'd0);
    chk({tag, "_open"}, 64'(bus.open_banks_o), 64'd0);
    chk({tag, "_error"}, 64'(bus.error_o), 64'd0);
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Reference model: packet queue plus per-bank open flag and row.
  logic [29:0] mq[$];
  logic [7:0]  mopen;
  logic [15:0] mrow [8];
  bit          merr, mwr_v, mrd_v;
  logic [31:0] mwr_d, mrd_d;
  logic [3:0]  mwr_m;

  task automatic model_reset();
    mq.delete();
    mopen = '0;
    for (int i = 0; i < 8; i++) mrow[i] = '0;
    merr = 0; mwr_v = 0; mrd_v = 0; mrd_d = '0; mwr_d = '0; mwr_m = '0;
  endtask

  task automatic model_step();
    bit deq, full, sel, act, rd, wr, pre, a10, closed;
    logic [2:0]  b, c;
    logic [15:0] row;
    deq  = (mq.size() != 0) && bus.cmd_ready_i;
    full = (mq.size() == ELS);
    sel  = !bus.dfi_cs_n_i;
    c    = {bus.dfi_ras_n_i, bus.dfi_cas_n_i, bus.dfi_we_n_i};
    act  = sel && c == C_ACT;
    rd   = sel && c == C_RD;
    wr   = sel && c == C_WR;
    pre  = sel && c == C_PRE;
    b    = bus.dfi_bank_i;
    a10  = bus.dfi_address_i[10];
    closed = !mopen[b];
    if (deq) void'(mq.pop_front());
    if (rd || wr) begin
      row = (ROWCHK && closed) ? 16'h0 : mrow[b];
      if (ROWCHK && closed) merr = 1;
      if (!full || deq) mq.push_back(pkt(wr, b, row, bus.dfi_address_i[9:0]));
      else merr = 1;
      if (a10) mopen[b] = 1'b0;
    end
    if (act) begin
      if (ROWCHK && mopen[b]) merr = 1;
      mopen[b] = 1'b1;
      mrow[b]  = bus.dfi_address_i;
    end
    if (pre) begin
      if (a10) mopen = '0;
      else mopen[b] = 1'b0;
    end
    if (mwr_v && !bus.wr_ready_i) merr = 1;
    mwr_v = bus.dfi_wrdata_en_i;
    mwr_d = bus.dfi_wrdata_i;
    mwr_m = bus.dfi_wrdata_mask_i;
    if (bus.dfi_rddata_en_i) begin
      mrd_d = bus.rd_v_i ? bus.rd_data_i : 32'hDEADBEEF;
      if (!bus.rd_v_i) merr = 1;
    end
    mrd_v = bus.dfi_rddata_en_i;
  endtask

  typedef struct {
    logic        cs_n;
    logic [2:0]  cmd;
    logic [2:0]  bank;
    logic [15:0] addr;
    logic        rdy;
    logic        exp_v;
    logic [29:0] exp_dat;
    logic [7:0]  exp_open;
  } vec_t;

  vec_t vt[10];

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    tick();

    vt[0] = '{1'b1, C_NOP, 3'd0, 16'h0000, 1'b0, 1'b0, 30'h0, 8'h00};
    vt[1] = '{1'b0, C_ACT, 3'd2, 16'h1234, 1'b0, 1'b0, 30'h0, 8'h04};
    vt[2] = '{1'b0, C_RD,  3'd2, 16'h0055, 1'b0, 1'b1, pkt(0, 3'd2, 16'h1234, 10'h055), 8'h04};
    vt[3] = '{1'b0, C_WR,  3'd2, 16'h04AA, 1'b1, 1'b1, pkt(1, 3'd2, 16'h1234, 10'h0AA), 8'h00};
    vt[4] = '{1'b0, C_ACT, 3'd5, 16'h00FF, 1'b1, 1'b0, 30'h0, 8'h20};
    vt[5] = '{1'b0, C_ACT, 3'd0, 16'hBEEF, 1'b0, 1'b0, 30'h0, 8'h21};
    vt[6] = '{1'b0, C_PRE, 3'd0, 16'h0400, 1'b0, 1'b0, 30'h0, 8'h00};
    vt[7] = '{1'b0, C_ACT, 3'd7, 16'h0001, 1'b0, 1'b0, 30'h0, 8'h80};
    vt[8] = '{1'b0, C_PRE, 3'd7, 16'h0000, 1'b0, 1'b0, 30'h0, 8'h00};
    vt[9] = '{1'b1, C_ACT, 3'd3, 16'h4444, 1'b0, 1'b0, 30'h0, 8'h00};
    for (int i = 0; i < 10; i++) begin
      set_cmd(vt[i].cs_n, vt[i].cmd, vt[i].bank, vt[i].addr);
      bus.cmd_ready_i = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_cmd_v", i), 64'(bus.cmd_v_o), 64'(vt[i].exp_v));
      if (vt[i].exp_v) chk($sformatf("vec%0d_cmd_data", i), 64'(bus.cmd_data_o), 64'(vt[i].exp_dat));
      chk($sformatf("vec%0d_open", i), 64'(bus.open_banks_o), 64'(vt[i].exp_open));
      chk($sformatf("vec%0d_error", i), 64'(bus.error_o), 64'd0);
    end

    // Overflow: five RDs into a four-deep FIFO with no dequeue.
    idle(); set_cmd(1'b0, C_ACT, 3'd1, 16'h0777); tick();
    for (int i = 1; i <= 5; i++) begin
      idle(); set_cmd(1'b0, C_RD, 3'd1, 16'(i)); tick();
    end
    idle(); tick();
    chk("ovf_error", 64'(bus.error_o), 64'd1);
    bus.cmd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_v%0d", k), 64'(bus.cmd_v_o), 64'd1);
      chk($sformatf("ovf_dat%0d", k), 64'(bus.cmd_data_o), 64'(pkt(0, 3'd1, 16'h0777, 10'(k + 1))));
      tick();
    end
    chk("ovf_drained", 64'(bus.cmd_v_o), 64'd0);
    do_reset();

    // Full FIFO with a dequeue on the fifth RD accepts it.
    idle(); set_cmd(1'b0, C_ACT, 3'd1, 16'h0777); tick();
    for (int i = 1; i <= 5; i++) begin
      idle(); set_cmd(1'b0, C_RD, 3'd1, 16'(i));
      bus.cmd_ready_i = (i == 5);
      tick();
    end
    idle(); tick();
    chk("fulldeq_error", 64'(bus.error_o), 64'd0);
    bus.cmd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fulldeq_v%0d", k), 64'(bus.cmd_v_o), 64'd1);
      chk($sformatf("fulldeq_dat%0d", k), 64'(bus.cmd_data_o), 64'(pkt(0, 3'd1, 16'h0777, 10'(k + 2))));
      tick();
    end
    chk("fulldeq_drained", 64'(bus.cmd_v_o), 64'd0);

    // Read path: served beat, then missing host data.
    idle();
    bus.dfi_rddata_en_i = 1'b1; bus.rd_v_i = 1'b1; bus.rd_data_i = 32'hA5A5A5A5;
    #1;
    chk("rd_yumi_hit", 64'(bus.rd_yumi_o), 64'd1);
    tick();
    chk("rd_valid_hit", 64'(bus.dfi_rddata_valid_o), 64'd1);
    chk("rd_data_hit", 64'(bus.dfi_rddata_o), 64'hA5A5A5A5);
    chk("rd_err_hit", 64'(bus.error_o), 64'd0);
    bus.rd_v_i = 1'b0;
    #1;
    chk("rd_yumi_miss", 64'(bus.rd_yumi_o), 64'd0);
    tick();
    chk("rd_data_miss", 64'(bus.dfi_rddata_o), 64'hDEADBEEF);
    chk("rd_err_miss", 64'(bus.error_o), 64'd1);
    idle(); tick();
    chk("rd_valid_off", 64'(bus.dfi_rddata_valid_o), 64'd0);
    do_reset();

    // Write beat into a stalled consumer.
    idle();
    bus.dfi_wrdata_en_i = 1'b1; bus.dfi_wrdata_i = 32'h12345678; bus.dfi_wrdata_mask_i = 4'b0010;
    bus.wr_ready_i = 1'b0;
    tick();
    chk("wr_v", 64'(bus.wr_v_o), 64'd1);
    chk("wr_data", 64'(bus.wr_data_o), 64'h12345678);
    chk("wr_mask", 64'(bus.wr_mask_o), 64'h2);
    chk("wr_err_early", 64'(bus.error_o), 64'd0);
    idle(); bus.wr_ready_i = 1'b0;
    tick();
    chk("wr_v_off", 64'(bus.wr_v_o), 64'd0);
    chk("wr_err", 64'(bus.error_o), 64'd1);
    do_reset();

    // RD to closed bank 5, then async reset mid-burst.
    idle(); set_cmd(1'b0, C_RD, 3'd5, 16'h0033); tick();
    chk("closed_rd_v", 64'(bus.cmd_v_o), 64'd1);
    chk("closed_rd_dat", 64'(bus.cmd_data_o), 64'(pkt(0, 3'd5, 16'h0, 10'h033)));
    chk("closed_rd_err", 64'(bus.error_o), 64'(ROWCHK));
    idle(); set_cmd(1'b0, C_ACT, 3'd3, 16'h00AB); tick();
    idle(); set_cmd(1'b0, C_RD, 3'd3, 16'h0011);
    bus.dfi_wrdata_en_i = 1'b1; bus.dfi_rddata_en_i = 1'b1; bus.rd_v_i = 1'b1;
    bus.rd_data_i = 32'h0F0F0F0F;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Random traffic against the model, three bias settings.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        logic [15:0] a;
        a = 16'($urandom);
        a[10] = ($urandom_range(0, 3) == 0);
        set_cmd(($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), a);
        bus.cmd_ready_i = (seg == 0) ? 1'b1 : (seg == 1) ? ($urandom_range(0, 9) == 0)
                                                          : ($urandom_range(0, 1) == 1);
        bus.dfi_wrdata_en_i = $urandom_range(0, 1) == 1;
        bus.dfi_wrdata_i = $urandom;
        bus.dfi_wrdata_mask_i = 4'($urandom);
        bus.wr_ready_i = (seg == 0) || ($urandom_range(0, 7) != 0);
        bus.dfi_rddata_en_i = $urandom_range(0, 1) == 1;
        bus.rd_v_i = (seg == 0) || ($urandom_range(0, 7) != 0);
        bus.rd_data_i = $urandom;
        #1;
        chk("rnd_yumi", 64'(bus.rd_yumi_o), 64'(bus.dfi_rddata_en_i && bus.rd_v_i));
        model_step();
        tick();
        chk("rnd_cmd_v", 64'(bus.cmd_v_o), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("rnd_cmd_data", 64'(bus.cmd_data_o), 64'(mq[0]));
        chk("rnd_open", 64'(bus.open_banks_o), 64'(mopen));
        chk("rnd_error", 64'(bus.error_o), 64'(merr));
        chk("rnd_wr_v", 64'(bus.wr_v_o), 64'(mwr_v));
        if (mwr_v) chk("rnd_wr_beat", {28'h0, bus.wr_mask_o, bus.wr_data_o}, {28'h0, mwr_m, mwr_d});
        chk("rnd_rd_valid", 64'(bus.dfi_rddata_valid_o), 64'(mrd_v));
        chk("rnd_rd_data", 64'(bus.dfi_rddata_o), 64'(mrd_d));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
